// File: rtl/count_seg7_driver.sv
`default_nettype none
// ============================================================================
//  Module   : count_seg7_driver
//  Purpose  : Shows a 4-bit counter value on a 4-digit multiplexed common-
//             anode seven-segment display. The digits are, from right to
//             left: decimal units, decimal tens (blank when zero), always
//             blank, and the hex glyph of the value. The decimal point on
//             digit0 flashes for FLASH_FRAMES scan frames after each change.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1  single clock, rising edge
//    reset  in   1  asynchronous reset, active low
//    q      in   4  counter value, asynchronous to clk
//    seg    out  7  segments, active low, seg[6]=a .. seg[0]=g
//    an     out  4  digit enables, active low, an[0] = rightmost digit
//    dp     out  1  decimal point, active low
// ============================================================================
module count_seg7_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] q,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W = $clog2(FLASH_FRAMES + 1);

    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [SC_W-1:0] SC_BLANK = SC_W'(BLANK_CYC);
    localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);
    localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLASH_FRAMES);
    localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1);
    localparam logic [6:0]      SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    // Active-high abcdefg glyphs, a in bit 6.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h7E;
            4'h1:    g = 7'h30;
            4'h2:    g = 7'h6D;
            4'h3:    g = 7'h79;
            4'h4:    g = 7'h33;
            4'h5:    g = 7'h5B;
            4'h6:    g = 7'h5F;
            4'h7:    g = 7'h70;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h7B;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h1F;
            4'hC:    g = 7'h4E;
            4'hD:    g = 7'h3D;
            4'hE:    g = 7'h4F;
            default: g = 7'h47;
        endcase
        return g;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      s1_q, s2_q, s3_q;
    logic [3:0]      disp_q, disp_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;

    logic            w_accept;
    logic            w_slot_end;
    logic            w_frame_end;
    logic            w_tens;
    logic [3:0]      w_units;
    logic            w_blank;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            s3_q    <= 4'd0;
            disp_q  <= 4'd0;
            sc_q    <= '0;
            fc_q    <= '0;
            state_q <= DIG0;
            seg_q   <= SEG_OFF;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            s1_q    <= q;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            disp_q  <= disp_d;
            sc_q    <= sc_d;
            fc_q    <= fc_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        sc_d    = sc_q + SC_ONE;
        fc_d    = fc_q;
        seg_d   = SEG_OFF;
        an_d    = 4'b1111;
        dp_d    = 1'b1;

        // Two equal consecutive samples at s2/s3 reject a multi-bit value
        // that was only transiently seen while the bus was skewing.
        w_accept    = (s2_q == s3_q) && (s2_q != disp_q);
        w_slot_end  = (sc_q == SC_LAST);
        w_frame_end = w_slot_end && (state_q == DIG3);

        if (w_slot_end) begin
            sc_d = '0;
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
        end

        if (w_accept) begin
            disp_d = s2_q;
        end

        // A new value restarts the flash even if a decrement lands this edge.
        if (w_accept) begin
            fc_d = FC_LOAD;
        end else if (w_frame_end && (fc_q != '0)) begin
            fc_d = fc_q - FC_ONE;
        end

        w_tens  = (disp_q >= 4'd10);
        w_units = w_tens ? (disp_q - 4'd10) : disp_q;

        // Ghosting guard: all digits and segments off at the start of a slot.
        w_blank = (sc_q < SC_BLANK);

        if (!w_blank) begin
            case (state_q)
                DIG0: begin
                    an_d  = 4'b1110;
                    seg_d = ~glyph(w_units);
                    dp_d  = (fc_q == '0);
                end
                DIG1: begin
                    an_d  = 4'b1101;
                    seg_d = w_tens ? ~glyph(4'd1) : SEG_OFF;
                end
                DIG2: begin
                    an_d  = 4'b1011;
                end
                default: begin
                    an_d  = 4'b0111;
                    seg_d = ~glyph(disp_q);
                end
            endcase
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seg7_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_seg7_driver
//  Purpose  : Self-checking bench for count_seg7_driver. A reference model
//             derives each cycle's expected outputs from elapsed time and the
//             sampled history of q and queues them; a monitor compares the
//             DUT outputs against the queue on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_count_seg7_driver;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FF = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    localparam exp_t RST_VAL = '{seg: 7'h7F, an: 4'b1111, dp: 1'b1};

    logic       clk;
    logic       reset;
    logic [3:0] q;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                   7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                                   7'h4E, 7'h3D, 7'h4F, 7'h47};

    exp_t exp_q [$];

    // Reference model state: edges since reset release, q sampled per edge,
    // displayed value and remaining flash frames.
    int k      = 0;
    int qh [$];
    int disp_m = 0;
    int fc_m   = 0;

    count_seg7_driver #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BL),
        .FLASH_FRAMES (FF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display for the cycle whose pre-edge time is t edges after
    // release, with value dv shown and fc flash frames remaining.
    function automatic exp_t model_out(input int t, input int dv, input int fc);
        exp_t e;
        logic [3:0] one;
        int pos;
        int slot;
        one  = 4'b0001;
        pos  = t % SD;
        slot = (t / SD) % 4;
        e    = RST_VAL;
        if (pos >= BL) begin
            e.an = ~(one << slot);
            case (slot)
                0: begin
                    e.seg = ~glyph_tab[dv % 10];
                    e.dp  = !(fc > 0);
                end
                1: if (dv >= 10) e.seg = ~glyph_tab[dv / 10];
                3: e.seg = ~glyph_tab[dv];
                default: ;
            endcase
        end
        return e;
    endfunction

    // Model: runs on every rising edge and queues the outputs the DUT will
    // present after that edge.
    initial begin
        int s2p;
        int s3p;
        forever begin
            @(posedge clk);
            if (!reset) begin
                k      = 0;
                qh.delete();
                disp_m = 0;
                fc_m   = 0;
                exp_q.push_back(RST_VAL);
            end else begin
                exp_q.push_back(model_out(k, disp_m, fc_m));
                // A value is taken once it has been sampled on two
                // consecutive edges, two synchronizer stages back.
                s2p = (k >= 2) ? qh[k-2] : 0;
                s3p = (k >= 3) ? qh[k-3] : 0;
                if (s2p == s3p && s2p != disp_m) begin
                    disp_m = s2p;
                    fc_m   = FF;
                end else if ((k % (4*SD)) == (4*SD - 1) && fc_m > 0) begin
                    fc_m = fc_m - 1;
                end
                qh.push_back(int'(q));
                k = k + 1;
            end
        end
    end

    // Monitor: compares on the falling edge. While reset is low the outputs
    // must sit at their reset values immediately, regardless of the clock.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!reset) e = RST_VAL;
                total = total + 1;
                if ({seg, an, dp} !== e) begin
                    bad = bad + 1;
                    $display("FAIL %s t=%0t: got seg=%h an=%b dp=%b, want seg=%h an=%b dp=%b",
                             phase, $time, seg, an, dp, e.seg, e.an, e.dp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        q = v;
        step(n);
    endtask

    initial begin
        bit found;
        q     = 4'd0;
        reset = 1'b0;
        step(3);

        phase = "reset_q0_scan";
        reset = 1'b1;
        hold(4'd0, 40);

        phase = "hold_13";
        hold(4'd13, 40);

        phase = "glitch_5A5";
        hold(4'd5, 80);
        hold(4'hA, 1);
        hold(4'd5, 40);

        phase = "flash_3to4";
        hold(4'd3, 90);
        hold(4'd4, 90);

        phase = "wrap_15to0";
        hold(4'd15, 80);
        hold(4'd0, 80);

        phase = "reset_in_dig2";
        q = 4'd9;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1);
            if (((k / SD) % 4) == 2 && (k % SD) == 4 && fc_m == 1) found = 1'b1;
        end
        total = total + 1;
        if (!found) begin
            bad = bad + 1;
            $display("FAIL reach_dig2_fc1: got not_reached want reached");
        end
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        hold(4'd0, 40);

        phase = "random";
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hold(4'($urandom_range(0, 15)), 1);
            end else if (r == 1) begin
                reset = 1'b0;
                step($urandom_range(1, 3));
                reset = 1'b1;
            end else begin
                hold(4'($urandom_range(0, 15)), $urandom_range(1, 40));
            end
        end
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_seg7_driver.md
COUNT_SEG7_DRIVER -- requirements
Module: count_seg7_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range >= 4.
REQ-002 SHALL provide parameter BLANK_CYC, default 16: blanked cycles at the start of each slot; legal range 1 to SCAN_DIV-2.
REQ-003 SHALL provide parameter FLASH_FRAMES, default 8: full scan frames the change-flash lasts; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port q, input, 4 bits: count value from the up/down counter; asynchronous to clk.
REQ-007 SHALL have port seg, output, 7 bits: segments, active-low; seg[6]=a down to seg[0]=g.
REQ-008 SHALL have port an, output, 4 bits: digit enables, active-low; an[0] is the rightmost digit.
REQ-009 SHALL have port dp, output, 1 bit: decimal point, active-low.

Function
REQ-010 SHALL pass q through a two-flop synchronizer (s1, s2) and a third register s3 holding the previous s2.
REQ-011 SHALL load disp_val <= s2 only when s2 == s3 and s2 != disp_val; a value of q held stable before edge N appears in disp_val at edge N+3.
REQ-012 SHALL never accept a value that was present for a single clk cycle at s2 (multi-bit skew filter).
REQ-013 SHALL derive tens = (disp_val >= 10) and units = disp_val - 10*tens, combinationally from disp_val.
REQ-014 SHALL assign digit content as follows:
  - digit0: units
  - digit1: tens, blanked when tens == 0
  - digit2: always blank
  - digit3: hex glyph of disp_val
REQ-015 SHALL encode glyphs as active-high abcdefg with a as MSB, inverted onto seg:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - blank = 00
REQ-016 SHALL run slot counter sc, counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-017 SHALL run scan FSM states DIG0->DIG1->DIG2->DIG3->DIG0, advancing on the edge where sc == SCAN_DIV-1; there are no other transitions.
REQ-018 SHALL drive an = 4'b1111 while sc < BLANK_CYC; otherwise an SHALL drive only the current state's digit low.
REQ-019 SHALL register seg, an and dp, so outputs reflect the state, sc and disp_val of the previous cycle (1-cycle output latency).
REQ-020 SHALL load flash counter fc with FLASH_FRAMES on every accepted disp_val change; a change arriving while fc != 0 SHALL reload it.
REQ-021 SHALL decrement fc on each DIG3->DIG0 transition while fc != 0; when a load and a decrement fall on the same edge, the load wins.
REQ-022 SHALL drive dp low only when the state is DIG0, fc != 0 and the digit is unblanked; otherwise dp = 1.
REQ-023 SHALL update disp_val mid-slot immediately, with the new glyph shown from the next cycle and no restart of the scan.

Reset
REQ-024 SHALL clear s1, s2, s3, disp_val, sc and fc to 0 and set the state to DIG0 while reset = 0, regardless of clk.
REQ-025 SHALL drive seg = 7'h7F, an = 4'b1111 and dp = 1 while reset = 0 and on the first cycle after release.
REQ-026 SHALL restart the scan from DIG0 with sc = 0 and no flash when reset is asserted mid-slot or mid-flash.
REQ-027 SHALL, after release with q = 0 held, show "0" on digit0 and "0" on digit3 without setting a flash, since disp_val already equals 0.

Verification (SCAN_DIV=8, BLANK_CYC=2, FLASH_FRAMES=2)
REQ-028 SHALL cover: release reset with q=0 -> an cycles 1110, 1101, 1011, 0111 every 8 clocks, each preceded by 2 clocks of 1111; seg=7'h01 on digit0 and digit3, 7'h7F on digit1 and digit2; dp=1 throughout.
REQ-029 SHALL cover: q=4'd13 held -> disp_val=13 at edge +3; digit0 seg=~7'h79, digit1 seg=~7'h30, digit3 seg=~7'h3D.
REQ-030 SHALL cover: a one-cycle q glitch 5->A->5 -> disp_val stays 5 and fc stays 0.
REQ-031 SHALL cover: q change 3->4 -> dp low during unblanked DIG0 slots for exactly 2 frames, then 1.
REQ-032 SHALL cover: q=15 held, then wrap to 0 -> digit1 blanks, digit3 shows 0 (seg=7'h01), flash restarts.
REQ-033 SHALL cover: reset pulse during DIG2 slot with fc=1 -> outputs at reset values immediately; after release the scan restarts at DIG0 with dp=1.
